mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// RV32M execution unit: pipelined multiplier plus iterative radix-2 divider.
// Exports per-entry in-flight tags for decode hazard detection.
module mult_div_unit #(
   parameter int WD_SIZE  = 32,
   parameter int REG_SIZE = 5,
   parameter int STAGES   = 5,
   parameter int DIV_EN   = 1
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             op_i,
   input  logic [2:0]                       funct3_i,
   input  logic [WD_SIZE-1:0]               op1_data_i,
   input  logic [WD_SIZE-1:0]               op2_data_i,
   input  logic [REG_SIZE-1:0]              rd_i,
   input  logic                             ctrl_reg_write_i,
   input  logic                             flush_i,
   output logic                             stall_o,
   output logic                             valid_result_o,
   output logic [WD_SIZE-1:0]               result_o,
   output logic [REG_SIZE-1:0]              rd_o,
   output logic                             ctrl_reg_write_o,
   output logic [STAGES:0]                  inflight_valid_o,
   output logic [(STAGES+1)*REG_SIZE-1:0]   inflight_rd_o
);

   localparam int CW = $clog2(WD_SIZE + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ITER,
      S_DONE
   } div_st_t;

   div_st_t r_state;
   div_st_t w_next;

   logic w_acc;
   logic w_mul_acc;
   logic w_div_acc;
   logic w_stall;
   logic w_busy;
   logic w_done;

   assign w_acc     = op_i & ~w_stall & ~flush_i;
   assign w_div_acc = w_acc & funct3_i[2] & (DIV_EN != 0);
   assign w_mul_acc = w_acc & ~w_div_acc;

   // ---------------- multiplier ----------------
   logic                      w_sa;
   logic                      w_sb;
   logic [2*WD_SIZE-1:0]      w_ma;
   logic [2*WD_SIZE-1:0]      w_mb;
   logic [2*WD_SIZE-1:0]      w_prod;
   logic [WD_SIZE-1:0]        w_mres;

   // Low 2*WD bits of the extended product hold both result words.
   always_comb begin
      w_sa   = (funct3_i[1:0] == 2'b01) | (funct3_i[1:0] == 2'b10);
      w_sb   = (funct3_i[1:0] == 2'b01);
      w_ma   = {{WD_SIZE{w_sa & op1_data_i[WD_SIZE-1]}}, op1_data_i};
      w_mb   = {{WD_SIZE{w_sb & op2_data_i[WD_SIZE-1]}}, op2_data_i};
      w_prod = w_ma * w_mb;
      w_mres = '0;
      if (!funct3_i[2]) begin
         if (funct3_i[1:0] == 2'b00)
            w_mres = w_prod[WD_SIZE-1:0];
         else
            w_mres = w_prod[2*WD_SIZE-1:WD_SIZE];
      end
   end

   logic [STAGES-1:0]         r_mv;
   logic [STAGES-1:0]         r_mwe;
   logic [REG_SIZE-1:0]       r_mrd  [STAGES];
   logic [WD_SIZE-1:0]        r_mres [STAGES];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mv  <= '0;
         r_mwe <= '0;
         for (int i = 0; i < STAGES; i++) begin
            r_mrd[i]  <= '0;
            r_mres[i] <= '0;
         end
      end else begin
         r_mv[0]   <= w_mul_acc;
         r_mwe[0]  <= ctrl_reg_write_i;
         r_mrd[0]  <= rd_i;
         r_mres[0] <= w_mres;
         for (int i = 1; i < STAGES; i++) begin
            r_mv[i]   <= r_mv[i-1] & ~flush_i;
            r_mwe[i]  <= r_mwe[i-1];
            r_mrd[i]  <= r_mrd[i-1];
            r_mres[i] <= r_mres[i-1];
         end
      end
   end

   // ---------------- divider ----------------
   logic [WD_SIZE-1:0]        r_a;
   logic [WD_SIZE-1:0]        r_b;
   logic                      r_sgn;
   logic                      r_rem_op;
   logic [REG_SIZE-1:0]       r_rd;
   logic                      r_we;
   logic                      r_neg_q;
   logic                      r_neg_r;
   logic                      r_dz;
   logic [WD_SIZE-1:0]        r_quo;
   logic [WD_SIZE-1:0]        r_dvs;
   logic [WD_SIZE-1:0]        r_rem;
   logic [CW-1:0]             r_cnt;

   logic [WD_SIZE-1:0]        w_abs_a;
   logic [WD_SIZE-1:0]        w_abs_b;
   logic [WD_SIZE:0]          w_sh;
   logic [WD_SIZE:0]          w_diff;
   logic                      w_ge;
   logic [WD_SIZE-1:0]        w_q;
   logic [WD_SIZE-1:0]        w_r;
   logic [WD_SIZE-1:0]        w_dres;

   always_comb begin
      w_abs_a = (r_sgn & r_a[WD_SIZE-1]) ? -r_a : r_a;
      w_abs_b = (r_sgn & r_b[WD_SIZE-1]) ? -r_b : r_b;
      w_sh    = {r_rem, r_quo[WD_SIZE-1]};
      w_diff  = w_sh - {1'b0, r_dvs};
      w_ge    = ~w_diff[WD_SIZE];
      w_q     = r_neg_q ? -r_quo : r_quo;
      w_r     = r_neg_r ? -r_rem : r_rem;
      // Divide by zero leaves |dividend| in the remainder naturally;
      // only the quotient needs overriding.
      if (r_rem_op)
         w_dres = w_r;
      else if (r_dz)
         w_dres = '1;
      else
         w_dres = w_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_sgn    <= 1'b0;
         r_rem_op <= 1'b0;
         r_rd     <= '0;
         r_we     <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_rem    <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_div_acc) begin
            r_a      <= op1_data_i;
            r_b      <= op2_data_i;
            r_sgn    <= ~funct3_i[0];
            r_rem_op <= funct3_i[1];
            r_rd     <= rd_i;
            r_we     <= ctrl_reg_write_i;
         end
         if (r_state == S_SETUP) begin
            r_neg_q <= r_sgn & (r_a[WD_SIZE-1] ^ r_b[WD_SIZE-1]);
            r_neg_r <= r_sgn & r_a[WD_SIZE-1];
            r_dz    <= (r_b == '0);
            r_quo   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_rem   <= '0;
            r_cnt   <= '0;
         end else if (r_state == S_ITER) begin
            r_rem <= w_ge ? w_diff[WD_SIZE-1:0] : w_sh[WD_SIZE-1:0];
            r_quo <= {r_quo[WD_SIZE-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_div_acc) w_next = S_SETUP;
         S_SETUP: w_next = S_ITER;
         S_ITER:  if (r_cnt == CW'(WD_SIZE - 1)) w_next = S_DONE;
         S_DONE:  w_next = w_div_acc ? S_SETUP : S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (flush_i)
         w_next = S_IDLE;
   end

   always_comb begin
      w_stall = (r_state == S_SETUP) | (r_state == S_ITER);
      w_busy  = (r_state != S_IDLE);
      w_done  = (r_state == S_DONE);
   end

   // ---------------- result port ----------------
   always_comb begin
      valid_result_o   = 1'b0;
      result_o         = '0;
      rd_o             = '0;
      ctrl_reg_write_o = 1'b0;
      unique case (1'b1)
         w_done: begin
            valid_result_o   = 1'b1;
            result_o         = w_dres;
            rd_o             = r_rd;
            ctrl_reg_write_o = r_we;
         end
         r_mv[STAGES-1]: begin
            valid_result_o   = 1'b1;
            result_o         = r_mres[STAGES-1];
            rd_o             = r_mrd[STAGES-1];
            ctrl_reg_write_o = r_mwe[STAGES-1];
         end
         default: ;
      endcase
   end

   assign stall_o          = w_stall;
   assign inflight_valid_o = {w_busy, r_mv};

   for (genvar g = 0; g < STAGES; g++) begin : g_ifrd
      assign inflight_rd_o[g*REG_SIZE +: REG_SIZE] = r_mrd[g];
   end
   assign inflight_rd_o[STAGES*REG_SIZE +: REG_SIZE] = r_rd;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit at STAGES = 5, 1 and 32,
// all fed the same stream and checked against an arithmetic model.
module tb_mult_div_unit;

   localparam int NC = 6000;
   localparam int DLAT = 34;

   logic clk = 1'b0;
   logic reset_n;
   logic op_i;
   logic [2:0] f3;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic [4:0] rd_i;
   logic we_i;
   logic flush_i;

   logic [2:0] stall;
   logic [2:0] vr;
   logic [2:0] we_o;
   logic [2:0][31:0] res;
   logic [2:0][4:0] rdo;
   logic [5:0] inf0;
   logic [29:0] infrd0;
   logic [1:0] inf1;
   logic [9:0] infrd1;
   logic [32:0] inf2;
   logic [164:0] infrd2;

   always #5 clk = ~clk;

   mult_div_unit #(.STAGES(5)) u0 (
      .clk(clk), .reset_n(reset_n), .op_i(op_i), .funct3_i(f3),
      .op1_data_i(a_i), .op2_data_i(b_i), .rd_i(rd_i),
      .ctrl_reg_write_i(we_i), .flush_i(flush_i), .stall_o(stall[0]),
      .valid_result_o(vr[0]), .result_o(res[0]), .rd_o(rdo[0]),
      .ctrl_reg_write_o(we_o[0]), .inflight_valid_o(inf0),
      .inflight_rd_o(infrd0));

   mult_div_unit #(.STAGES(1)) u1 (
      .clk(clk), .reset_n(reset_n), .op_i(op_i), .funct3_i(f3),
      .op1_data_i(a_i), .op2_data_i(b_i), .rd_i(rd_i),
      .ctrl_reg_write_i(we_i), .flush_i(flush_i), .stall_o(stall[1]),
      .valid_result_o(vr[1]), .result_o(res[1]), .rd_o(rdo[1]),
      .ctrl_reg_write_o(we_o[1]), .inflight_valid_o(inf1),
      .inflight_rd_o(infrd1));

   mult_div_unit #(.STAGES(32)) u2 (
      .clk(clk), .reset_n(reset_n), .op_i(op_i), .funct3_i(f3),
      .op1_data_i(a_i), .op2_data_i(b_i), .rd_i(rd_i),
      .ctrl_reg_write_i(we_i), .flush_i(flush_i), .stall_o(stall[2]),
      .valid_result_o(vr[2]), .result_o(res[2]), .rd_o(rdo[2]),
      .ctrl_reg_write_o(we_o[2]), .inflight_valid_o(inf2),
      .inflight_rd_o(infrd2));

   bit          ev  [3][NC];
   logic [31:0] er  [3][NC];
   logic [4:0]  erd [3][NC];
   bit          ewe [3][NC];
   bit          mul_at [NC];
   logic [4:0]  rd_at  [NC];
   int          div_d = -1000;
   logic [4:0]  div_rd = '0;
   int          cyc = 0;
   bit          accepted;
   int          nchk = 0;
   int          nfail = 0;
   logic [31:0] last_res [3];

   logic [2:0]  cf [6] = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd7};
   logic [31:0] ca [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000,
                           32'hFFFFFFFB, 32'd7};
   logic [31:0] cb [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                           32'd0, 32'd0};
   logic [31:0] ce [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0,
                           32'hFFFFFFFF, 32'd7};

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic int lat(input int k);
      return (k == 0) ? 5 : (k == 1) ? 1 : 32;
   endfunction

   function automatic logic [31:0] ref_op(input logic [2:0] f,
         input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p;
      logic [63:0] ua, ub, up;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'h0, a};
      ub = {32'h0, b};
      p  = 0;
      up = 0;
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin up = ua * ub; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFFFFFF;
            up = ua / ub;
            return up[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
            p = sa % sb;
            return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            up = ua % ub;
            return up[31:0];
         end
      endcase
   endfunction

   function automatic bit exp_stall(input int c);
      return (c >= div_d + 1) && (c <= div_d + DLAT - 1);
   endfunction

   function automatic bit exp_busy(input int c);
      return (c >= div_d + 1) && (c <= div_d + DLAT);
   endfunction

   task automatic chk_infl(input int k, input int c,
         input logic [32:0] iv, input logic [164:0] ir);
      logic [32:0] e;
      int s;
      s = lat(k);
      e = '0;
      for (int i = 0; i < s; i++)
         if (c - 1 - i >= 0) e[i] = mul_at[c-1-i];
      e[s] = exp_busy(c);
      chk($sformatf("inflight%0d", k), iv, e);
      for (int i = 0; i < s; i++)
         if (e[i]) chk($sformatf("infrd%0d_%0d", k, i),
                       ir[i*5 +: 5], rd_at[c-1-i]);
      if (e[s]) chk($sformatf("infrd%0d_div", k), ir[s*5 +: 5], div_rd);
   endtask

   task automatic check_outputs(input int c);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("valid%0d", k), vr[k], ev[k][c]);
         chk($sformatf("stall%0d", k), stall[k], exp_stall(c));
         if (ev[k][c]) begin
            chk($sformatf("result%0d", k), res[k], er[k][c]);
            chk($sformatf("rd%0d", k), rdo[k], erd[k][c]);
            chk($sformatf("we%0d", k), we_o[k], ewe[k][c]);
         end else begin
            chk($sformatf("we_gate%0d", k), we_o[k], 1'b0);
         end
         if (vr[k]) last_res[k] = res[k];
      end
      chk_infl(0, c, {27'b0, inf0}, {135'b0, infrd0});
      chk_infl(1, c, {31'b0, inf1}, {155'b0, infrd1});
      chk_infl(2, c, inf2, infrd2);
   endtask

   task automatic model_update(input int c);
      logic [31:0] r;
      int t;
      accepted = 1'b0;
      if (flush_i) begin
         for (int k = 0; k < 3; k++)
            for (int j = c + 1; j <= c + 40; j++) ev[k][j] = 1'b0;
         for (int j = c - 40; j < c; j++)
            if (j >= 0) mul_at[j] = 1'b0;
         div_d = -1000;
      end else if (op_i && !exp_stall(c)) begin
         accepted = 1'b1;
         r = ref_op(f3, a_i, b_i);
         if (f3[2]) begin
            div_d  = c;
            div_rd = rd_i;
         end else begin
            mul_at[c] = 1'b1;
            rd_at[c]  = rd_i;
         end
         for (int k = 0; k < 3; k++) begin
            t = f3[2] ? c + DLAT : c + lat(k);
            ev[k][t]  = 1'b1;
            er[k][t]  = r;
            erd[k][t] = rd_i;
            ewe[k][t] = we_i;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs(cyc);
      model_update(cyc);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a,
         input logic [31:0] b, input logic [4:0] rd, input logic we);
      op_i = 1'b1;
      f3 = f;
      a_i = a;
      b_i = b;
      rd_i = rd;
      we_i = we;
      accepted = 1'b0;
      for (int n = 0; n < 80 && !accepted; n++) tick();
      if (!accepted) chk("accept_timeout", 1'b0, 1'b1);
      op_i = 1'b0;
   endtask

   task automatic do_reset();
      op_i = 1'b0;
      flush_i = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_valid", vr, 3'b0);
      chk("rst_stall", stall, 3'b0);
      chk("rst_infl0", inf0, 6'b0);
      chk("rst_infl2", inf2, 33'b0);
      for (int k = 0; k < 3; k++)
         for (int j = cyc; j <= cyc + 40; j++) ev[k][j] = 1'b0;
      for (int j = cyc - 40; j <= cyc; j++)
         if (j >= 0) mul_at[j] = 1'b0;
      div_d = -1000;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc++;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         5: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      op_i = 1'b0;
      f3 = '0;
      a_i = '0;
      b_i = '0;
      rd_i = '0;
      we_i = 1'b0;
      flush_i = 1'b0;
      for (int k = 0; k < 3; k++) last_res[k] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", vr, 3'b0);
      chk("rst_result0", res[0], 32'h0);
      chk("rst_rd0", rdo[0], 5'h0);
      chk("rst_we", we_o, 3'b0);
      chk("rst_stall", stall, 3'b0);
      chk("rst_infl0", inf0, 6'b0);
      chk("rst_infrd0", infrd0, 30'b0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc = 0;

      issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 1'b1);
      idle(6);
      chk("mul7x-3_s5", last_res[0], 32'hFFFFFFEB);
      chk("mul7x-3_s1", last_res[1], 32'hFFFFFFEB);

      issue(3'd1, 32'h80000000, 32'hFFFFFFFF, 5'd1, 1'b1);
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd2, 1'b1);
      issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 5'd3, 1'b1);
      idle(6);
      chk("mulhu", last_res[0], 32'h7FFFFFFF);
      idle(30);
      chk("mulhu_s32", last_res[2], 32'h7FFFFFFF);

      issue(3'd4, 32'hFFFFFFF9, 32'd2, 5'd6, 1'b1);
      idle(DLAT);
      chk("div-7/2", last_res[0], 32'hFFFFFFFD);
      issue(3'd6, 32'hFFFFFFF9, 32'd2, 5'd7, 1'b1);
      idle(DLAT);
      chk("rem-7/2", last_res[0], 32'hFFFFFFFF);

      issue(3'd4, 32'hFFFFFFF9, 32'd2, 5'd8, 1'b1);
      issue(3'd0, 32'd3, 32'd4, 5'd9, 1'b1);
      idle(6);
      chk("held_mul", last_res[0], 32'd12);

      for (int i = 0; i < 6; i++) begin
         issue(cf[i], ca[i], cb[i], 5'(20 + i), 1'b1);
         idle(DLAT);
         chk($sformatf("corner%0d", i), last_res[0], ce[i]);
      end

      issue(3'd0, 32'd3, 32'd5, 5'd10, 1'b1);
      issue(3'd4, 32'd100, 32'd7, 5'd11, 1'b1);
      idle(36);
      chk("s32_order", last_res[2], 32'd14);

      issue(3'd0, 32'd9, 32'd9, 5'd12, 1'b1);
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush_mul_infl", inf0, 6'b0);
      idle(6);

      issue(3'd4, 32'd1000, 32'd3, 5'd13, 1'b1);
      idle(8);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush_div_stall", stall[0], 1'b0);
      chk("flush_div_infl", inf0, 6'b0);
      idle(40);

      issue(3'd5, 32'd1000, 32'd3, 5'd14, 1'b1);
      idle(10);
      do_reset();
      idle(40);

      for (int n = 0; n < 2500; n++) begin
         op_i = ($urandom_range(0, 99) < 60);
         if ($urandom_range(0, 99) < 12)
            f3 = 3'(4 + $urandom_range(0, 3));
         else
            f3 = 3'($urandom_range(0, 3));
         a_i = pick();
         b_i = pick();
         rd_i = 5'($urandom_range(0, 31));
         we_i = 1'($urandom_range(0, 1));
         flush_i = ($urandom_range(0, 99) < 2);
         tick();
      end
      op_i = 1'b0;
      flush_i = 1'b0;
      idle(40);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
